// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: icache request/response, hazard and redirect inputs,
// and the IF/ID producer fields. The fetch unit uses the master modport.
interface if_fetch_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall_IF;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] instruction;
    logic [31:0] imemaddr_IF;
    logic [31:0] next_imemaddr;
    logic        enable_IF_ID;
    logic        flush_IF_ID;
    logic        halted;

    modport master (
        input  ihit, iload, stall_IF, redirect_valid, redirect_addr,
        output imemREN, imemaddr, instruction, imemaddr_IF, next_imemaddr,
               enable_IF_ID, flush_IF_ID, halted
    );

    modport slave (
        output ihit, iload, stall_IF, redirect_valid, redirect_addr,
        input  imemREN, imemaddr, instruction, imemaddr_IF, next_imemaddr,
               enable_IF_ID, flush_IF_ID, halted
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests from the icache and feeds IF/ID,
// buffering one instruction under hazard stalls and stopping on HALT.
//   state  | meaning
//   FETCH  | requesting icache at pc, delivering on ihit
//   HOLD   | instruction parked in ibuf while IF/ID is stalled
//   HALTED | HALT delivered, fetch stopped until redirect or reset
module if_fetch_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic           CLK,
    input  logic           nRST,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        bus.imemREN       = (state_q == FETCH);
        bus.imemaddr      = pc_q;
        bus.instruction   = (state_q == HOLD) ? ibuf_q : bus.iload;
        bus.imemaddr_IF   = pc_q;
        bus.next_imemaddr = pc_plus4;
        bus.flush_IF_ID   = bus.redirect_valid;
        bus.halted        = (state_q == HALTED);
        bus.enable_IF_ID  = 1'b0;

        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;

        // Redirect outranks everything: any data arriving this cycle is wrong-path.
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_addr;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.ihit && !bus.stall_IF) begin
                        bus.enable_IF_ID = 1'b1;
                        pc_d             = pc_plus4;
                        state_d          = (bus.iload[31:26] == HALT_OPCODE) ? HALTED : FETCH;
                    end else if (bus.ihit) begin
                        ibuf_d  = bus.iload;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.stall_IF) begin
                        bus.enable_IF_ID = 1'b1;
                        pc_d             = pc_plus4;
                        state_d          = (ibuf_q[31:26] == HALT_OPCODE) ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            ibuf_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: scoreboard of expected IF/ID deliveries
// plus per-scenario inline checks of control outputs.
module tb_if_fetch_unit;

    logic CLK;
    logic nRST;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .PC_INIT     (32'h0000_0000),
        .HALT_OPCODE (6'h3F)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every IF/ID load must match the oldest expected delivery.
    always @(negedge CLK) begin
        if (bus.enable_IF_ID === 1'b1) begin
            exp_t e;
            checks++;
            if (bus.flush_IF_ID !== 1'b0) begin
                errors++;
                $display("FAIL enable_with_flush: flush=%b required 0", bus.flush_IF_ID);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: ins=%h pc=%h required no delivery",
                         bus.instruction, bus.imemaddr_IF);
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus.instruction !== e.ins || bus.imemaddr_IF !== e.pc ||
                    bus.next_imemaddr !== e.npc) begin
                    errors++;
                    $display("FAIL delivery: got ins=%h pc=%h npc=%h required ins=%h pc=%h npc=%h",
                             bus.instruction, bus.imemaddr_IF, bus.next_imemaddr,
                             e.ins, e.pc, e.npc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ihit           = 1'b0;
        bus.iload          = 32'h0;
        bus.stall_IF       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic expect_delivery(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        e.npc = pc + 32'd4;
        sb.push_back(e);
    endtask

    // Unstalled fetches of non-HALT instructions starting at start_pc.
    task automatic fetch_n(input int n, input logic [31:0] start_pc);
        logic [31:0] ins;
        for (int i = 0; i < n; i++) begin
            ins = $urandom & 32'h03FF_FFFF;
            bus.ihit     = 1'b1;
            bus.stall_IF = 1'b0;
            bus.iload    = ins;
            expect_delivery(ins, start_pc + 32'(i * 4));
            next_cycle();
        end
        bus.ihit = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d deliveries missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLK);
        checks++;
        if (bus.imemREN !== 1'b1) begin errors++; $display("FAIL reset_imemREN: got %b required 1", bus.imemREN); end
        checks++;
        if (bus.imemaddr !== 32'h0) begin errors++; $display("FAIL reset_imemaddr: got %h required 0", bus.imemaddr); end
        checks++;
        if (bus.enable_IF_ID !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b required 0", bus.enable_IF_ID); end
        checks++;
        if (bus.flush_IF_ID !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b required 0", bus.flush_IF_ID); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", bus.halted); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [2];
        ins[0] = 32'h2001_0001;
        ins[1] = 32'h2002_0002;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            bus.ihit  = 1'b1;
            bus.iload = ins[i];
            expect_delivery(ins[i], 32'(i * 4));
            @(negedge CLK);
            checks++;
            if (bus.imemaddr !== 32'(i * 4)) begin
                errors++; $display("FAIL b2b_imemaddr: got %h required %h", bus.imemaddr, 32'(i * 4));
            end
            checks++;
            if (bus.enable_IF_ID !== 1'b1) begin
                errors++; $display("FAIL b2b_enable: got %b required 1", bus.enable_IF_ID);
            end
            next_cycle();
        end
        idle_inputs();
        check_drained("b2b");
    endtask

    task automatic test_stall();
        apply_reset();
        fetch_n(4, 32'h0);
        bus.ihit     = 1'b1;
        bus.stall_IF = 1'b1;
        bus.iload    = 32'hAABB_CCDD;
        @(negedge CLK);
        checks++;
        if (bus.enable_IF_ID !== 1'b0) begin errors++; $display("FAIL stall_capture_enable: got %b required 0", bus.enable_IF_ID); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.iload = $urandom;
            @(negedge CLK);
            checks++;
            if (bus.imemREN !== 1'b0 || bus.enable_IF_ID !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: imemREN=%b enable=%b required 0 0", bus.imemREN, bus.enable_IF_ID);
            end
            next_cycle();
        end
        bus.stall_IF = 1'b0;
        bus.ihit     = 1'b0;
        expect_delivery(32'hAABB_CCDD, 32'h10);
        @(negedge CLK);
        checks++;
        if (bus.enable_IF_ID !== 1'b1) begin errors++; $display("FAIL stall_release_enable: got %b required 1", bus.enable_IF_ID); end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h14) begin
            errors++;
            $display("FAIL stall_next_req: imemREN=%b addr=%h required 1 00000014", bus.imemREN, bus.imemaddr);
        end
        next_cycle();
        check_drained("stall");
    endtask

    task automatic test_redirect();
        apply_reset();
        fetch_n(8, 32'h0);
        bus.ihit           = 1'b1;
        bus.iload          = 32'h1234_5678;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h100;
        @(negedge CLK);
        checks++;
        if (bus.enable_IF_ID !== 1'b0 || bus.flush_IF_ID !== 1'b1) begin
            errors++;
            $display("FAIL redirect_ctrl: enable=%b flush=%b required 0 1", bus.enable_IF_ID, bus.flush_IF_ID);
        end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (bus.imemaddr !== 32'h100) begin errors++; $display("FAIL redirect_target: got %h required 00000100", bus.imemaddr); end
        next_cycle();
        fetch_n(1, 32'h100);
        check_drained("redirect");
    endtask

    task automatic test_hold_redirect();
        apply_reset();
        bus.ihit     = 1'b1;
        bus.stall_IF = 1'b1;
        bus.iload    = 32'h0BAD_0BAD;
        next_cycle();
        bus.ihit           = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h40;
        @(negedge CLK);
        checks++;
        if (bus.flush_IF_ID !== 1'b1 || bus.enable_IF_ID !== 1'b0) begin
            errors++;
            $display("FAIL hold_redirect_ctrl: flush=%b enable=%b required 1 0", bus.flush_IF_ID, bus.enable_IF_ID);
        end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h40) begin
            errors++;
            $display("FAIL hold_redirect_fetch: imemREN=%b addr=%h required 1 00000040", bus.imemREN, bus.imemaddr);
        end
        next_cycle();
        fetch_n(1, 32'h40);
        check_drained("hold_redirect");
    endtask

    task automatic test_halt();
        apply_reset();
        fetch_n(2, 32'h0);
        bus.ihit  = 1'b1;
        bus.iload = 32'hFC00_0000;
        expect_delivery(32'hFC00_0000, 32'h8);
        @(negedge CLK);
        checks++;
        if (bus.enable_IF_ID !== 1'b1) begin errors++; $display("FAIL halt_deliver: got %b required 1", bus.enable_IF_ID); end
        next_cycle();
        bus.iload = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.halted !== 1'b1 || bus.imemREN !== 1'b0) begin
                errors++;
                $display("FAIL halted_state: halted=%b imemREN=%b required 1 0", bus.halted, bus.imemREN);
            end
            next_cycle();
        end
        bus.ihit           = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        @(negedge CLK);
        checks++;
        if (bus.flush_IF_ID !== 1'b1) begin errors++; $display("FAIL halt_redirect_flush: got %b required 1", bus.flush_IF_ID); end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (bus.halted !== 1'b0 || bus.imemREN !== 1'b1 || bus.imemaddr !== 32'h200) begin
            errors++;
            $display("FAIL halt_resume: halted=%b imemREN=%b addr=%h required 0 1 00000200",
                     bus.halted, bus.imemREN, bus.imemaddr);
        end
        next_cycle();
        fetch_n(1, 32'h200);
        check_drained("halt");
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFFC;
        next_cycle();
        idle_inputs();
        fetch_n(1, 32'hFFFF_FFFC);
        @(negedge CLK);
        checks++;
        if (bus.imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h required 00000000", bus.imemaddr); end
        next_cycle();
        check_drained("wrap");
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        fetch_n(12, 32'h0);
        bus.ihit     = 1'b1;
        bus.stall_IF = 1'b1;
        bus.iload    = 32'hDEAD_BEEF;
        next_cycle();
        bus.ihit = 1'b0;
        nRST     = 1'b0;
        #1;
        checks++;
        if (bus.imemaddr !== 32'h0 || bus.imemREN !== 1'b1 || bus.enable_IF_ID !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%h imemREN=%b enable=%b required 00000000 1 0",
                     bus.imemaddr, bus.imemREN, bus.enable_IF_ID);
        end
        bus.stall_IF = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.enable_IF_ID !== 1'b0 || bus.imemaddr !== 32'h0) begin
                errors++;
                $display("FAIL reset_no_stale: enable=%b addr=%h required 0 00000000",
                         bus.enable_IF_ID, bus.imemaddr);
            end
            next_cycle();
        end
        check_drained("reset_hold");
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_hold_redirect();
        test_halt();
        test_wrap();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
